// File: rtl/count_display.sv
// Display side of the frequency meter: snapshots the four BCD count digits on each latch pulse
// and scans them onto a 4-digit multiplexed 7-segment display, with leading-zero blanking and overflow dashes.
module count_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       latch,
    input  logic [3:0] th_d,
    input  logic [3:0] hundred_d,
    input  logic [3:0] ten_d,
    input  logic [3:0] one_d,
    output logic [6:0] seg,
    output logic [3:0] dig_sel,
    output logic       valid,
    output logic       ovf
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_DASH = 7'h40;

    logic [3:0][3:0] snap_q, snap_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      dig_sel_q, dig_sel_d;

    logic            pre_wrap_c;
    logic            in_ovf_c;
    logic [3:0]      lz_c;
    logic [3:0]      cur_c;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h00;
        endcase
    endfunction

    // Next-state: prescaler/scan index free-run, snapshot on latch, registered scan outputs.
    always_comb begin
        snap_d    = snap_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        seg_d     = 7'h00;
        dig_sel_d = 4'b1111;

        pre_wrap_c = (pre_q == PRE_LAST);
        pre_d      = pre_wrap_c ? '0 : pre_q + PW'(1);
        idx_d      = pre_wrap_c ? idx_q + 2'd1 : idx_q;

        in_ovf_c = (th_d > 4'd9) || (hundred_d > 4'd9) || (ten_d > 4'd9) || (one_d > 4'd9);
        if (latch) begin
            snap_d  = {th_d, hundred_d, ten_d, one_d};
            valid_d = 1'b1;
            ovf_d   = in_ovf_c;
        end

        // lz_c[k]: every snapshot digit at position >= k is zero; ones digit is never blanked.
        lz_c[3] = (snap_q[3] == 4'd0);
        lz_c[2] = lz_c[3] && (snap_q[2] == 4'd0);
        lz_c[1] = lz_c[2] && (snap_q[1] == 4'd0);
        lz_c[0] = 1'b0;

        cur_c = snap_q[idx_q];
        if (valid_q) begin
            dig_sel_d = ~(4'b0001 << idx_q);
            if (ovf_q) begin
                seg_d = SEG_DASH;
            end else if (BLANK_LZ && lz_c[idx_q]) begin
                seg_d = 7'h00;
            end else begin
                seg_d = bcd_to_seg(cur_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            snap_q    <= '0;
            pre_q     <= '0;
            idx_q     <= 2'd0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            seg_q     <= 7'h00;
            dig_sel_q <= 4'b1111;
        end else begin
            snap_q    <= snap_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;
    assign valid   = valid_q;
    assign ovf     = ovf_q;

endmodule
